// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: byte-serial multi-byte add/subtract sequencer driving one 8-bit adder per cycle, LSB first.
// Optional zero flag output is built when ZERO_FLAG_EN is defined.
module serial_addsub_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                op,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                overflow
`ifdef ZERO_FLAG_EN
    ,
    output logic                zero
`endif
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic          carry;
    logic          op_q;
    logic [W-1:0]  a_q, b_q;
    logic [7:0]    a_byte, b_byte, s_byte;
    logic          c_byte;
    logic          last;
    logic          accept;

    // status outputs and next state; start is only honoured outside RUN
    always_comb begin
        busy     = state == RUN;
        done     = state == DONE;
        accept   = (state != RUN) && start;
        last     = idx == IW'(NBYTES - 1);
        state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    // byte adder for the current index; subtraction feeds the inverted B byte
    always_comb begin
        a_byte           = a_q[{idx, 3'b000} +: 8];
        b_byte           = op_q ? ~b_q[{idx, 3'b000} +: 8] : b_q[{idx, 3'b000} +: 8];
        {c_byte, s_byte} = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // operand latch, byte sequencing and final flag capture
    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            carry     <= 1'b0;
            op_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            idx   <= '0;
            carry <= op;
        end else if (state == RUN) begin
            result[{idx, 3'b000} +: 8] <= s_byte;
            carry <= c_byte;
            idx   <= last ? idx : idx + 1'b1;
            if (last) begin
                carry_out <= c_byte;
                overflow  <= (a_byte[7] == b_byte[7]) && (s_byte[7] != a_byte[7]);
            end
        end
    end

`ifdef ZERO_FLAG_EN
    logic zero_acc;

    // running "all bytes so far are zero", published with carry_out on the last byte
    always_ff @(posedge clock) begin
        if (reset) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            zero_acc <= 1'b1;
        end else if (state == RUN) begin
            zero_acc <= zero_acc & (s_byte == 8'h00);
            if (last) zero <= zero_acc & (s_byte == 8'h00);
        end
    end
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed and random checks of the byte-serial add/sub sequencer against an arithmetic model.
module tb_serial_addsub_ctrl;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));
    localparam longint UMAX = (longint'(1) <<< W) - 1;

    logic         clock = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a, b, result;
    logic         busy, done, carry_out, overflow;
`ifdef ZERO_FLAG_EN
    logic         zero;
    logic         exp_z;
`endif
    logic [W-1:0] exp_r;
    logic         exp_c, exp_v;
    int           n_chk  = 0;
    int           n_fail = 0;

    always #5 clock = ~clock;

    serial_addsub_ctrl #(.NBYTES(NBYTES)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
`ifdef ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // whole-word arithmetic: unsigned for result/carry, signed range test for overflow
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                                  output logic [W-1:0] r, output logic c, output logic v);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint u  = o ? ux - uy : ux + uy;
        longint s  = o ? sx - sy : sx + sy;
        r = u[W-1:0];
        c = o ? (ux >= uy) : (u > UMAX);
        v = (s > SMAX) || (s < SMIN);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom % 7)
            0: return '0;
            1: return 1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return '1;
            default: return $urandom;
        endcase
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        model(x, y, o, exp_r, exp_c, exp_v);
`ifdef ZERO_FLAG_EN
        exp_z = exp_r == '0;
`endif
        a = x; b = y; op = o; start = 1'b1;
        tick;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 1'($urandom);
    endtask

    task automatic await_done(input string tag, input bit pester);
        int cyc = 0;
        chk({tag, " busy"}, busy, 1);
        while (!done && cyc < 4 * NBYTES) begin
            if (pester) begin
                start = 1'b1; a = $urandom; b = $urandom; op = 1'($urandom);
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " latency"}, cyc, NBYTES);
        chk({tag, " result"}, result, exp_r);
        chk({tag, " carry_out"}, carry_out, exp_c);
        chk({tag, " overflow"}, overflow, exp_v);
        chk({tag, " busy@done"}, busy, 0);
`ifdef ZERO_FLAG_EN
        chk({tag, " zero"}, zero, exp_z);
`endif
    endtask

    task automatic to_idle(input string tag);
        tick;
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " held result"}, result, exp_r);
    endtask

    initial begin
        bit saw;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) tick;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst carry_out", carry_out, 0);
        chk("rst overflow", overflow, 0);
        reset = 1'b0;
        tick;
        chk("idle done", done, 0);

        launch(32'h000000FF, 32'h00000001, 1'b0);
        await_done("t1 add", 0);
        to_idle("t1");

        launch(32'h00000000, 32'h00000001, 1'b1);
        await_done("t2 sub borrow", 0);
        to_idle("t2");

        launch(32'h7FFFFFFF, 32'h00000001, 1'b0);
        await_done("t3 ovf", 0);
        to_idle("t3");
        launch(32'hFFFFFFFF, 32'h00000001, 1'b0);
        await_done("t3 carry", 0);
        to_idle("t3b");

        launch(32'h11111111, 32'h22222222, 1'b0);
        await_done("t4 ignore", 1);
        launch(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b1);
        await_done("t4 b2b", 0);
        to_idle("t4");

        launch(32'h12345678, 32'h00000001, 1'b1);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t5 busy", busy, 0);
        chk("t5 done", done, 0);
        chk("t5 result", result, 0);
        chk("t5 carry_out", carry_out, 0);
        chk("t5 overflow", overflow, 0);
        saw = 1'b0;
        repeat (8) begin
            tick;
            saw |= done | busy;
        end
        chk("t5 stays idle", saw, 0);
        launch(32'h12345678, 32'h00000001, 1'b1);
        await_done("t5 fresh", 0);
        to_idle("t5");

`ifdef ZERO_FLAG_EN
        launch(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        await_done("t6 zero", 0);
        to_idle("t6");
        launch(32'h00000001, 32'h00000001, 1'b0);
        await_done("t6 nonzero", 0);
        to_idle("t6b");
`endif

        for (int i = 0; i < 40; i++) begin
            launch(pick(), pick(), 1'($urandom));
            await_done("rnd", 0);
            if ($urandom % 2 == 1) to_idle("rnd");
        end
        to_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
